// File: rtl/rgb_pwm_driver.sv
// RGB LED PWM driver: per-channel duty registers shadowed at period wrap, gated by switch inputs.
// Optional macro FADE_EN: active duty ramps one step per period toward the written target.
module rgb_pwm_driver #(
    parameter int NUM_LEDS = 2,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 4,
    localparam int CH = 3 * NUM_LEDS,
    localparam int AW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH-1:0]       in,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [PWM_BITS-1:0] wr_data,
    output logic [CH-1:0]       out,
    output logic                period_done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] DMAX = '1;

    logic [PW-1:0]       presc;
    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] pending [CH];
    logic [PWM_BITS-1:0] active  [CH];
    logic [PWM_BITS-1:0] target  [CH];
    logic [CH-1:0]       wr_sel;
    logic                tick;
    logic                wrap;

`ifdef FADE_EN
    function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] cur,
                                                        input logic [PWM_BITS-1:0] tgt);
        if (cur < tgt) return cur + PWM_BITS'(1);
        if (cur > tgt) return cur - PWM_BITS'(1);
        return cur;
    endfunction
`endif

    assign tick = (presc == PRESC_LAST);
    assign wrap = tick && (cnt == DMAX);

    // A write landing on the wrap cycle is visible to the shadow copy in that same cycle.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < CH; i++) begin
            wr_sel[i] = wr_en && (int'(wr_addr) == i);
            target[i] = wr_sel[i] ? wr_data : pending[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc       <= '0;
            cnt         <= '0;
            out         <= '0;
            period_done <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
        end else begin
            presc       <= tick ? '0 : presc + PW'(1);
            period_done <= wrap;
            if (tick) begin
                cnt <= cnt + PWM_BITS'(1);
            end
            for (int i = 0; i < CH; i++) begin
                // Full duty is forced on so there is no one-step dark gap at the period end.
                out[i] <= in[i] && ((active[i] == DMAX) || (cnt < active[i]));
                if (wr_sel[i]) begin
                    pending[i] <= wr_data;
                end
                if (wrap) begin
`ifdef FADE_EN
                    active[i] <= step_toward(active[i], target[i]);
`else
                    active[i] <= target[i];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Self-checking bench for rgb_pwm_driver: directed PWM scenarios plus randomized traffic vs a reference model.
module tb_rgb_pwm_driver;

    localparam int CH  = 6;
    localparam int PER = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] in = '0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [5:0] out;
    logic       pd;
    logic [5:0] out3;
    logic       pd3;

    int n_checks = 0;
    int n_fail   = 0;
    int hi_cnt [CH];
    int mm_cnt;
    int pd_cnt;

    always #5 clk = ~clk;

    rgb_pwm_driver #(.NUM_LEDS(2), .PWM_BITS(8), .PRESCALE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in(in), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .out(out), .period_done(pd)
    );

    rgb_pwm_driver #(.NUM_LEDS(2), .PWM_BITS(8), .PRESCALE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in(in), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .out(out3), .period_done(pd3)
    );

    // Reference model for the PRESCALE=1 instance: time since reset release, period phase = t mod 256.
    int         m_t;
    logic [7:0] m_pend [CH];
    logic [7:0] m_act  [CH];
    logic [5:0] m_out;
    logic       m_pd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t   <= 0;
            m_out <= '0;
            m_pd  <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                m_pend[i] <= '0;
                m_act[i]  <= '0;
            end
        end else begin
            m_t  <= m_t + 1;
            m_pd <= (m_t % PER) == PER - 1;
            for (int i = 0; i < CH; i++) begin
                m_out[i] <= in[i] && (m_act[i] == 8'hFF || (m_t % PER) < int'(m_act[i]));
                if (wr_en && int'(wr_addr) == i) m_pend[i] <= wr_data;
                if ((m_t % PER) == PER - 1) begin
`ifdef FADE_EN
                    if ((wr_en && int'(wr_addr) == i ? wr_data : m_pend[i]) > m_act[i])
                        m_act[i] <= m_act[i] + 8'd1;
                    else if ((wr_en && int'(wr_addr) == i ? wr_data : m_pend[i]) < m_act[i])
                        m_act[i] <= m_act[i] - 8'd1;
`else
                    m_act[i] <= (wr_en && int'(wr_addr) == i) ? wr_data : m_pend[i];
`endif
                end
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_ch(input int a, input int d);
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = 8'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_pd(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (pd) begin ok = 1'b1; break; end
        end
    endtask

    task automatic measure(input int n);
        for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
        mm_cnt = 0; pd_cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) if (out[c]) hi_cnt[c]++;
            if (pd) pd_cnt++;
            if (out !== m_out || pd !== m_pd) mm_cnt++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wr_en = 1'b0; in = '0;
        tick_n(3);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bit ok;
        rst_n = 1'b0; in = '1;
        tick_n(4);
        n_checks++; if (out !== 6'b0) begin n_fail++; $display("FAIL reset_out: got %b expected %b", out, 6'b0); end
        n_checks++; if (pd !== 1'b0) begin n_fail++; $display("FAIL reset_pd: got %b expected 0", pd); end
        rst_n = 1'b1;
        write_ch(0, 255);
        wait_pd(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL reset_wrap_timeout: got no period_done expected one"); end
        tick_n(20);
        n_checks++; if (out !== m_out) begin n_fail++; $display("FAIL pre_reset_out: got %b expected %b", out, m_out); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out !== 6'b0) begin n_fail++; $display("FAIL async_reset_out: got %b expected %b", out, 6'b0); end
        @(negedge clk);
        in = '0;
        tick_n(1);
        rst_n = 1'b1;
    endtask

    task automatic test_duty();
        bit ok;
        in = 6'b000001;
        write_ch(0, 64);
        wait_pd(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL duty_wrap_timeout: got no period_done expected one"); end
        measure(PER);
        n_checks++; if (hi_cnt[0] != 64) begin n_fail++; $display("FAIL duty64_high: got %0d expected 64", hi_cnt[0]); end
        n_checks++; if (hi_cnt[1] + hi_cnt[2] + hi_cnt[3] + hi_cnt[4] + hi_cnt[5] != 0) begin
            n_fail++; $display("FAIL duty_others_off: got %0d high cycles expected 0", hi_cnt[1] + hi_cnt[2] + hi_cnt[3] + hi_cnt[4] + hi_cnt[5]);
        end
        n_checks++; if (mm_cnt != 0) begin n_fail++; $display("FAIL duty_model: got %0d mismatches expected 0", mm_cnt); end
    endtask

    task automatic test_extremes();
        bit ok;
        write_ch(1, 0);
        write_ch(2, 255);
        in = 6'b000111;
        wait_pd(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ext_wrap_timeout: got no period_done expected one"); end
        measure(3 * PER);
        n_checks++; if (hi_cnt[1] != 0) begin n_fail++; $display("FAIL duty0_high: got %0d expected 0", hi_cnt[1]); end
        n_checks++; if (hi_cnt[2] != 3 * PER) begin n_fail++; $display("FAIL duty255_high: got %0d expected %0d", hi_cnt[2], 3 * PER); end
        n_checks++; if (hi_cnt[0] != 3 * 64) begin n_fail++; $display("FAIL ext_ch0_high: got %0d expected %0d", hi_cnt[0], 3 * 64); end
        n_checks++; if (pd_cnt != 3) begin n_fail++; $display("FAIL ext_pd_count: got %0d expected 3", pd_cnt); end
    endtask

    task automatic test_shadow();
        int hi3;
        bit ok;
        tick_n(10);
        in[3] = 1'b1;
        write_ch(3, 200);
        hi3 = 0; ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (pd) begin ok = 1'b1; break; end
            if (out[3]) hi3++;
        end
        n_checks++; if (!ok || hi3 != 0) begin n_fail++; $display("FAIL shadow_hold: got %0d high (wrap %0b) expected 0 high before wrap", hi3, ok); end
        measure(PER);
        n_checks++; if (hi_cnt[3] != 200) begin n_fail++; $display("FAIL shadow_duty200: got %0d expected 200", hi_cnt[3]); end
        tick_n(PER - 1);
        write_ch(3, 50);
        n_checks++; if (pd !== 1'b1) begin n_fail++; $display("FAIL bypass_align: got pd %b expected 1", pd); end
        measure(PER);
        n_checks++; if (hi_cnt[3] != 50) begin n_fail++; $display("FAIL bypass_duty50: got %0d expected 50", hi_cnt[3]); end
        n_checks++; if (mm_cnt != 0) begin n_fail++; $display("FAIL shadow_model: got %0d mismatches expected 0", mm_cnt); end
    endtask

    task automatic test_bad_addr_gate();
        bit ok;
        in[4] = 1'b1;
        write_ch(4, 128);
        wait_pd(ok);
        write_ch(6, 255);
        write_ch(7, 255);
        wait_pd(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL badaddr_wrap_timeout: got no period_done expected one"); end
        measure(PER);
        n_checks++; if (hi_cnt[1] != 0 || hi_cnt[5] != 0) begin
            n_fail++; $display("FAIL badaddr_off: got ch1=%0d ch5=%0d expected 0 0", hi_cnt[1], hi_cnt[5]);
        end
        n_checks++; if (hi_cnt[4] != 128 || hi_cnt[3] != 50 || hi_cnt[0] != 64) begin
            n_fail++; $display("FAIL badaddr_keep: got ch0=%0d ch3=%0d ch4=%0d expected 64 50 128", hi_cnt[0], hi_cnt[3], hi_cnt[4]);
        end
        tick_n(20);
        n_checks++; if (out[4] !== 1'b1) begin n_fail++; $display("FAIL gate_before: got %b expected 1", out[4]); end
        in[4] = 1'b0;
        @(negedge clk);
        n_checks++; if (out[4] !== 1'b0) begin n_fail++; $display("FAIL gate_off: got %b expected 0", out[4]); end
        in[4] = 1'b1;
        @(negedge clk);
        n_checks++; if (out[4] !== 1'b1) begin n_fail++; $display("FAIL gate_on: got %b expected 1", out[4]); end
        wait_pd(ok);
        measure(PER);
        n_checks++; if (hi_cnt[4] != 128) begin n_fail++; $display("FAIL gate_retained: got %0d expected 128", hi_cnt[4]); end
        n_checks++; if (mm_cnt != 0) begin n_fail++; $display("FAIL gate_model: got %0d mismatches expected 0", mm_cnt); end
    endtask

    task automatic test_fade();
        int exp_hi;
        bit ok;
        do_reset();
        in = 6'b000001;
        write_ch(0, 3);
        wait_pd(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL fade_wrap_timeout: got no period_done expected one"); end
        for (int p = 1; p <= 4; p++) begin
            exp_hi = (p > 3) ? 3 : p;
            measure(PER);
            n_checks++; if (hi_cnt[0] != exp_hi) begin n_fail++; $display("FAIL fade_step%0d: got %0d expected %0d", p, hi_cnt[0], exp_hi); end
            n_checks++; if (pd_cnt != 1 || pd !== 1'b1) begin n_fail++; $display("FAIL fade_pd_period%0d: got %0d pulses expected 1", p, pd_cnt); end
        end
        n_checks++; if (mm_cnt != 0) begin n_fail++; $display("FAIL fade_model: got %0d mismatches expected 0", mm_cnt); end
    endtask

    task automatic test_prescale();
        int hi0, pulses;
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (pd3) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL presc_timeout: got no period_done expected one"); end
        hi0 = 0; pulses = 0;
        for (int k = 0; k < 3 * PER; k++) begin
            @(negedge clk);
            if (out3[0]) hi0++;
            if (pd3) pulses++;
        end
        n_checks++; if (pulses != 1 || pd3 !== 1'b1) begin n_fail++; $display("FAIL presc_period: got %0d pulses (end %b) expected 1 at cycle 768", pulses, pd3); end
`ifndef FADE_EN
        n_checks++; if (hi0 != 3 * 64) begin n_fail++; $display("FAIL presc_duty: got %0d expected %0d", hi0, 3 * 64); end
`endif
        @(negedge clk);
        n_checks++; if (pd3 !== 1'b0) begin n_fail++; $display("FAIL presc_pd_width: got %b expected 0", pd3); end
    endtask

    task automatic test_random();
        int mm;
        mm = 0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (out !== m_out || pd !== m_pd) mm++;
            if (k == 2000) begin
                do_reset();
                continue;
            end
            wr_en = 1'b0;
            if ($urandom_range(0, 15) == 0) in = 6'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                wr_en   = 1'b1;
                wr_addr = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 3))
                    0:       wr_data = 8'h00;
                    1:       wr_data = 8'hFF;
                    default: wr_data = 8'($urandom);
                endcase
            end
        end
        wr_en = 1'b0;
        n_checks++; if (mm != 0) begin n_fail++; $display("FAIL random_model: got %0d mismatches expected 0", mm); end
    endtask

    initial begin
        test_reset();
`ifdef FADE_EN
        test_fade();
`else
        test_duty();
        test_extremes();
        test_shadow();
        test_bad_addr_gate();
`endif
        test_prescale();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
